// File: rtl/seq_multiplier_16bit_if.sv
// Operand/result bundle for seq_multiplier_16bit.
//   master : drives start, a, b; observes p, load_en, busy (requester side)
//   slave  : the multiplier itself
// Signals:
//   start    request, sampled only while the multiplier is idle
//   a, b     multiplicand / multiplier, latched with an accepted start
//   p        2*WIDTH-bit product, feeds the downstream register D input
//   load_en  one-cycle pulse when p is valid, feeds the register EN input
//   busy     high from the cycle after start is accepted through DONE
interface seq_multiplier_16bit_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] p;
  logic               load_en;
  logic               busy;

  modport master (output start, a, b, input p, load_en, busy);
  modport slave  (input start, a, b, output p, load_en, busy);
endinterface

// File: rtl/seq_multiplier_16bit.sv
// Shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// The product register p_q drives the downstream register D input and
// load_en (high only in DONE) drives its EN, so the register captures each
// product exactly once.
// Ports:
//   clk_i    system clock, all state on the rising edge
//   reset_i  synchronous active-high reset, overrides start
//   bus      seq_multiplier_16bit_if.slave (start/a/b in, p/load_en/busy out)
// Build option:
//   SEQ_MULT_EARLY_EXIT_EN  when defined, RUN ends as soon as the remaining
//                           multiplier bits are all zero (same product,
//                           data-dependent latency). Undefined: RUN always
//                           takes WIDTH cycles.
module seq_multiplier_16bit #(
  parameter int WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  seq_multiplier_16bit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               last_iter;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    last_iter = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
        // No set bits left to add: the accumulator is already final.
        last_iter = (mplier_d == '0);
`else
        last_iter = (cnt_q == CW'(WIDTH - 1));
`endif
        if (last_iter) begin
          state_d = DONE;
          // Capture this edge's sum, including the final add.
          p_d     = acc_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign bus.p       = p_q;
  assign bus.load_en = (state_q == DONE);
  assign bus.busy    = (state_q != IDLE);

endmodule
